race_ctl: RTL

//   Game sequencer for the racer display pipeline. Owns the race state machine
//   and drives the layer-enable inputs (bg/track/player visible) and the player

---
 rtl/race_ctl_if.sv | 34 +++
 rtl/race_ctl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/race_ctl_if.sv
// Purpose: groups the racer sequencer's frame/button inputs and its draw-chain outputs.
// Latency: none; wires only.
// Backpressure: none; level and pulse signals only, with no handshake.
//
// master: the sequencer. It samples vsync and the buttons and drives the layer
//         enables, the sprite position, speed, lap and state.
// slave:  the surrounding system. It drives vsync and the buttons and consumes
//         the outputs.
interface race_ctl_if;
  logic        vsync;
  logic        btn_start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        bg_visible;
  logic        track_visible;
  logic        player_visible;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic [3:0]  speed;
  logic [3:0]  lap;
  logic [2:0]  state;

  modport master (
    input  vsync, btn_start, btn_up, btn_down, btn_left, btn_right,
    output bg_visible, track_visible, player_visible, xpos, ypos, speed, lap, state
  );

  modport slave (
    output vsync, btn_start, btn_up, btn_down, btn_left, btn_right,
    input  bg_visible, track_visible, player_visible, xpos, ypos, speed, lap, state
  );
endinterface

// File: rtl/race_ctl.sv
// Purpose: race game sequencer. It runs the race FSM, moves the car once per frame and counts laps.
// Latency: each output updates on the pclk edge after the qualifying start edge or vsync edge.
// Backpressure: none; inputs are sampled every cycle, and one press of start gives one event.
//
// Ports: pclk/rst (synchronous, active-high) are plain ports. bus (master) carries
//        vsync and the buttons as inputs, and the layer enables, xpos/ypos, speed,
//        lap and state as registered outputs.
module race_ctl #(
  parameter int SCREEN_W  = 1024,
  parameter int SCREEN_H  = 768,
  parameter int CAR_W     = 64,
  parameter int CAR_H     = 64,
  parameter int START_X   = 480,
  parameter int START_Y   = 640,
  parameter int STEP_X    = 4,
  parameter int MAX_SPEED = 8,
  parameter int CD_FRAMES = 180,
  parameter int LAPS      = 3
) (
  input logic        pclk,
  input logic        rst,
  race_ctl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RACE      = 3'd2,
    S_PAUSE     = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam int                CD_W    = $clog2(CD_FRAMES + 1);
  localparam logic [CD_W-1:0]   CD_LAST = CD_W'(CD_FRAMES - 1);
  localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - CAR_W);
  localparam logic signed [11:0] Y_SPAN  = 12'(SCREEN_H - CAR_H);
  localparam logic signed [11:0] STEP    = 12'(STEP_X);
  localparam logic signed [11:0] SPD_MAX = 12'(MAX_SPEED);
  localparam logic [10:0]        X0      = 11'(START_X);
  localparam logic [10:0]        Y0      = 11'(START_Y);
  localparam logic [3:0]         LAP_END = 4'(LAPS);

  state_t          st;
  logic            vsync_q;
  logic            start_q;
  logic [CD_W-1:0] cd;
  logic [10:0]     xpos_r;
  logic [10:0]     ypos_r;
  logic [3:0]      speed_r;
  logic [3:0]      lap_r;
  logic            bg_r;
  logic            trk_r;
  logic            ply_r;

  logic tick;
  logic start_ev;

  assign tick     = bus.vsync & ~vsync_q;
  assign start_ev = bus.btn_start & ~start_q;

  // Candidate next-frame values for RACE. All arithmetic uses 12-bit signed
  // values, so a step below zero shows up as a negative number and never wraps.
  logic signed [11:0] spd_c, spd_n;
  logic signed [11:0] x_c, x_n;
  logic signed [11:0] y_c, y_d, y_n;
  logic               wrap;
  logic [3:0]         lap_n;
  logic               done;

  always_comb begin
    spd_c = $signed({8'd0, speed_r});
    x_c   = $signed({1'b0, xpos_r});
    y_c   = $signed({1'b0, ypos_r});

    // Brake has priority over accelerate. The new speed drives this frame's move.
    spd_n = spd_c;
    if (bus.btn_down) begin
      if (spd_c > 12'sd0) spd_n = spd_c - 12'sd1;
    end else if (bus.btn_up) begin
      if (spd_c < SPD_MAX) spd_n = spd_c + 12'sd1;
    end

    // Opposite steer inputs cancel each other.
    x_n = x_c;
    if (bus.btn_left && !bus.btn_right) begin
      x_n = (x_c < STEP) ? 12'sd0 : x_c - STEP;
    end else if (bus.btn_right && !bus.btn_left) begin
      x_n = (x_c + STEP > X_MAX) ? X_MAX : x_c + STEP;
    end

    // The track scrolls upward. Going past the top wraps to the bottom and counts a lap.
    y_d   = y_c - spd_n;
    wrap  = (y_d < 12'sd0);
    y_n   = wrap ? y_d + Y_SPAN : y_d;
    lap_n = lap_r + {3'd0, wrap};
    done  = wrap && (lap_n == LAP_END);
  end

  // The clamping above keeps the upper bits zero. They are only kept so the
  // full-width intermediates stay visible.
  logic unused_hi;
  assign unused_hi = &{1'b0, spd_n[11:4], x_n[11], y_n[11]};

  always_ff @(posedge pclk) begin
    if (rst) begin
      st      <= S_IDLE;
      vsync_q <= 1'b0;
      start_q <= 1'b0;
      cd      <= '0;
      xpos_r  <= X0;
      ypos_r  <= Y0;
      speed_r <= 4'd0;
      lap_r   <= 4'd0;
      bg_r    <= 1'b1;
      trk_r   <= 1'b0;
      ply_r   <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      start_q <= bus.btn_start;
      bg_r    <= 1'b1;
      case (st)
        S_IDLE: begin
          if (start_ev) begin
            st      <= S_COUNTDOWN;
            xpos_r  <= X0;
            ypos_r  <= Y0;
            speed_r <= 4'd0;
            lap_r   <= 4'd0;
            cd      <= '0;
            trk_r   <= 1'b1;
            ply_r   <= 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            if (cd == CD_LAST) begin
              st <= S_RACE;
              cd <= '0;
            end else begin
              cd <= cd + CD_W'(1);
            end
          end
        end
        S_RACE: begin
          // A start press takes priority and suppresses any move on this frame.
          if (start_ev) begin
            st <= S_PAUSE;
          end else if (tick) begin
            xpos_r  <= x_n[10:0];
            ypos_r  <= y_n[10:0];
            lap_r   <= lap_n;
            speed_r <= done ? 4'd0 : spd_n[3:0];
            if (done) st <= S_FINISH;
          end
        end
        S_PAUSE: begin
          if (start_ev) st <= S_RACE;
        end
        S_FINISH: begin
          if (start_ev) begin
            st      <= S_IDLE;
            xpos_r  <= X0;
            ypos_r  <= Y0;
            speed_r <= 4'd0;
            trk_r   <= 1'b0;
            ply_r   <= 1'b0;
          end
        end
        default: begin
          st    <= S_IDLE;
          trk_r <= 1'b0;
          ply_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state          = st;
  assign bus.xpos           = xpos_r;
  assign bus.ypos           = ypos_r;
  assign bus.speed          = speed_r;
  assign bus.lap            = lap_r;
  assign bus.bg_visible     = bg_r;
  assign bus.track_visible  = trk_r;
  assign bus.player_visible = ply_r;

endmodule
